// File: rtl/reorder_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : reorder_buffer_if
// Brief    : Issue, result-broadcast, lookup, retire and flush signals of the ROB
// Revision : 1.0
// ============================================================================
interface reorder_buffer_if #(
    parameter int ROB_WIDTH = 4
);
    logic                 issue;
    logic [1:0]           issue_type;
    logic [4:0]           issue_rd;
    logic                 issue_ready;
    logic [31:0]          issue_val;
    logic                 issue_pred_jump;
    logic                 rob_full;
    logic [ROB_WIDTH-1:0] next_rob_pos;

    logic                 alu_result;
    logic [ROB_WIDTH-1:0] alu_rob_pos;
    logic [31:0]          alu_val;
    logic                 alu_jump;
    logic [31:0]          alu_next_pc;
    logic                 lsb_result;
    logic [ROB_WIDTH-1:0] lsb_rob_pos;
    logic [31:0]          lsb_val;

    logic [ROB_WIDTH-1:0] q1_pos;
    logic [ROB_WIDTH-1:0] q2_pos;
    logic                 q1_ready;
    logic                 q2_ready;
    logic [31:0]          q1_val;
    logic [31:0]          q2_val;

    logic                 commit;
    logic [4:0]           commit_rd;
    logic [31:0]          commit_val;
    logic [ROB_WIDTH-1:0] commit_rob_pos;
    logic                 commit_store;
    logic                 rollback;
    logic [31:0]          rollback_pc;

    modport master (
        output issue, issue_type, issue_rd, issue_ready, issue_val, issue_pred_jump,
        output alu_result, alu_rob_pos, alu_val, alu_jump, alu_next_pc,
        output lsb_result, lsb_rob_pos, lsb_val, q1_pos, q2_pos,
        input  rob_full, next_rob_pos, q1_ready, q2_ready, q1_val, q2_val,
        input  commit, commit_rd, commit_val, commit_rob_pos, commit_store,
        input  rollback, rollback_pc
    );

    modport slave (
        input  issue, issue_type, issue_rd, issue_ready, issue_val, issue_pred_jump,
        input  alu_result, alu_rob_pos, alu_val, alu_jump, alu_next_pc,
        input  lsb_result, lsb_rob_pos, lsb_val, q1_pos, q2_pos,
        output rob_full, next_rob_pos, q1_ready, q2_ready, q1_val, q2_val,
        output commit, commit_rd, commit_val, commit_rob_pos, commit_store,
        output rollback, rollback_pc
    );
endinterface
`default_nettype wire

// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module   : reorder_buffer
// Brief    : Circular in-order retire buffer with operand forwarding and flush
// Revision : 1.0
// ============================================================================
module reorder_buffer #(
    parameter int ROB_WIDTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    reorder_buffer_if.slave rob
);
    localparam int DEPTH = 1 << ROB_WIDTH;
    localparam int CW    = ROB_WIDTH + 1;
    localparam logic [1:0] c_type_reg = 2'b00;
    localparam logic [1:0] c_type_br  = 2'b01;
    localparam logic [1:0] c_type_st  = 2'b10;

    typedef logic [ROB_WIDTH-1:0] idx_t;

    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] r_ready;
    logic [DEPTH-1:0] r_pred;
    logic [DEPTH-1:0] r_jump;
    logic [1:0]       r_type [DEPTH];
    logic [4:0]       r_rd   [DEPTH];
    logic [31:0]      r_val  [DEPTH];
    logic [31:0]      r_npc  [DEPTH];
    idx_t             r_head;
    idx_t             r_tail;
    logic [CW-1:0]    r_count;

    logic             r_commit;
    logic             r_commit_store;
    logic [4:0]       r_commit_rd;
    logic [31:0]      r_commit_val;
    idx_t             r_commit_pos;
    logic             r_rollback;
    logic [31:0]      r_rollback_pc;

    logic             w_full;
    logic             w_live;
    logic             w_issue;
    logic             w_retire;
    logic             w_mispredict;
    logic             w_alu_wr;
    logic             w_lsb_wr;
    logic [DEPTH-1:0] w_busy_n;
    logic [DEPTH-1:0] w_ready_n;
    logic [32:0]      w_q1;
    logic [32:0]      w_q2;

    // The flush cycle is dead: nothing is accepted or retired while rollback is up.
    assign w_full       = (r_count == CW'(DEPTH));
    assign w_live       = rdy && !r_rollback;
    assign w_issue      = w_live && rob.issue && !w_full;
    assign w_retire     = w_live && (r_count != '0) && r_ready[r_head];
    assign w_mispredict = w_retire && (r_type[r_head] == c_type_br) &&
                          (r_jump[r_head] != r_pred[r_head]);
    assign w_alu_wr     = w_live && rob.alu_result && r_busy[rob.alu_rob_pos];
    assign w_lsb_wr     = w_live && rob.lsb_result && r_busy[rob.lsb_rob_pos];

    // Retire is applied last so a late result to the departing head cannot revive it.
    always_comb begin
        w_busy_n  = r_busy;
        w_ready_n = r_ready;
        if (w_alu_wr) w_ready_n[rob.alu_rob_pos] = 1'b1;
        if (w_lsb_wr) w_ready_n[rob.lsb_rob_pos] = 1'b1;
        if (w_issue) begin
            w_busy_n[r_tail]  = 1'b1;
            w_ready_n[r_tail] = rob.issue_ready;
        end
        if (w_retire) begin
            w_busy_n[r_head]  = 1'b0;
            w_ready_n[r_head] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy         <= '0;
            r_ready        <= '0;
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_commit       <= 1'b0;
            r_commit_store <= 1'b0;
            r_commit_rd    <= '0;
            r_commit_val   <= '0;
            r_commit_pos   <= '0;
            r_rollback     <= 1'b0;
            r_rollback_pc  <= '0;
        end else if (rdy) begin
            r_commit       <= 1'b0;
            r_commit_store <= 1'b0;
            r_rollback     <= 1'b0;
            if (w_mispredict) begin
                r_busy        <= '0;
                r_ready       <= '0;
                r_head        <= '0;
                r_tail        <= '0;
                r_count       <= '0;
                r_rollback    <= 1'b1;
                r_rollback_pc <= r_npc[r_head];
            end else begin
                r_busy  <= w_busy_n;
                r_ready <= w_ready_n;
                r_count <= r_count + CW'(w_issue) - CW'(w_retire);
                if (w_issue)  r_tail <= r_tail + idx_t'(1);
                if (w_retire) begin
                    r_head <= r_head + idx_t'(1);
                    if (r_type[r_head] == c_type_reg) begin
                        r_commit     <= 1'b1;
                        r_commit_rd  <= r_rd[r_head];
                        r_commit_val <= r_val[r_head];
                        r_commit_pos <= r_head;
                    end else if (r_type[r_head] == c_type_st) begin
                        r_commit_store <= 1'b1;
                        r_commit_pos   <= r_head;
                    end
                end
            end
        end
    end

    // Entry payload needs no reset: busy/ready gate every use of it.
    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_type[r_tail] <= rob.issue_type;
            r_rd[r_tail]   <= rob.issue_rd;
            r_val[r_tail]  <= rob.issue_val;
            r_pred[r_tail] <= rob.issue_pred_jump;
            r_jump[r_tail] <= rob.issue_pred_jump;
            r_npc[r_tail]  <= '0;
        end
        if (w_alu_wr) begin
            r_val[rob.alu_rob_pos]  <= rob.alu_val;
            r_jump[rob.alu_rob_pos] <= rob.alu_jump;
            r_npc[rob.alu_rob_pos]  <= rob.alu_next_pc;
        end
        if (w_lsb_wr) r_val[rob.lsb_rob_pos] <= rob.lsb_val;
    end

    always_comb begin
        w_q1 = '0;
        if (r_ready[rob.q1_pos])                                 w_q1 = {1'b1, r_val[rob.q1_pos]};
        else if (rob.alu_result && rob.alu_rob_pos == rob.q1_pos) w_q1 = {1'b1, rob.alu_val};
        else if (rob.lsb_result && rob.lsb_rob_pos == rob.q1_pos) w_q1 = {1'b1, rob.lsb_val};
        w_q2 = '0;
        if (r_ready[rob.q2_pos])                                 w_q2 = {1'b1, r_val[rob.q2_pos]};
        else if (rob.alu_result && rob.alu_rob_pos == rob.q2_pos) w_q2 = {1'b1, rob.alu_val};
        else if (rob.lsb_result && rob.lsb_rob_pos == rob.q2_pos) w_q2 = {1'b1, rob.lsb_val};
    end

    assign rob.rob_full       = w_full;
    assign rob.next_rob_pos   = r_tail;
    assign rob.q1_ready       = w_q1[32];
    assign rob.q1_val         = w_q1[31:0];
    assign rob.q2_ready       = w_q2[32];
    assign rob.q2_val         = w_q2[31:0];
    assign rob.commit         = r_commit;
    assign rob.commit_rd      = r_commit_rd;
    assign rob.commit_val     = r_commit_val;
    assign rob.commit_rob_pos = r_commit_pos;
    assign rob.commit_store   = r_commit_store;
    assign rob.rollback       = r_rollback;
    assign rob.rollback_pc    = r_rollback_pc;
endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reorder_buffer
// Brief    : Directed and randomized checks of reorder_buffer against a queue model
// Revision : 1.0
// ============================================================================
module tb_reorder_buffer;
    logic clk = 1'b0;
    logic rst;
    logic rdy;

    always #5 clk = ~clk;

    reorder_buffer_if #(.ROB_WIDTH(4)) bus ();

    reorder_buffer #(.ROB_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .rob (bus)
    );

    typedef struct {
        logic [3:0]  pos;
        logic [1:0]  typ;
        logic [4:0]  rd;
        logic [31:0] val;
        bit          ready;
        bit          pred;
        bit          jump;
        logic [31:0] npc;
    } ent_t;

    ent_t        q[$];
    int          mtail;
    bit          e_commit, e_store, e_rollback;
    logic [4:0]  e_rd;
    logic [31:0] e_val, e_rbpc;
    logic [3:0]  e_pos;

    int checks   = 0;
    int failures = 0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int find(logic [3:0] p);
        foreach (q[i]) if (q[i].pos == p) return i;
        return -1;
    endfunction

    function automatic logic [32:0] fwd(logic [3:0] p);
        foreach (q[i]) if (q[i].pos == p && q[i].ready) return {1'b1, q[i].val};
        if (bus.alu_result && bus.alu_rob_pos == p) return {1'b1, bus.alu_val};
        if (bus.lsb_result && bus.lsb_rob_pos == p) return {1'b1, bus.lsb_val};
        return 33'd0;
    endfunction

    task automatic check_outputs();
        logic [32:0] f;
        check("rob_full", 32'(bus.rob_full), 32'(q.size() == 16));
        check("next_rob_pos", 32'(bus.next_rob_pos), 32'(mtail));
        f = fwd(bus.q1_pos);
        check("q1_ready", 32'(bus.q1_ready), 32'(f[32]));
        check("q1_val", bus.q1_val, f[31:0]);
        f = fwd(bus.q2_pos);
        check("q2_ready", 32'(bus.q2_ready), 32'(f[32]));
        check("q2_val", bus.q2_val, f[31:0]);
        check("commit", 32'(bus.commit), 32'(e_commit));
        check("commit_rd", 32'(bus.commit_rd), 32'(e_rd));
        check("commit_val", bus.commit_val, e_val);
        check("commit_rob_pos", 32'(bus.commit_rob_pos), 32'(e_pos));
        check("commit_store", 32'(bus.commit_store), 32'(e_store));
        check("rollback", 32'(bus.rollback), 32'(e_rollback));
        check("rollback_pc", bus.rollback_pc, e_rbpc);
    endtask

    // One clock edge of the architectural behaviour, applied to the queue model.
    task automatic model_step();
        bit   was_full, retire;
        ent_t e, n;
        int   k;
        if (rst) begin
            q.delete();
            mtail = 0;
            e_commit = 0; e_store = 0; e_rollback = 0;
            e_rd = '0; e_val = '0; e_pos = '0; e_rbpc = '0;
            return;
        end
        if (!rdy) return;
        e_commit = 0;
        e_store  = 0;
        if (e_rollback) begin
            e_rollback = 0;
            return;
        end
        was_full = (q.size() == 16);
        retire   = (q.size() > 0) && q[0].ready;
        if (retire) e = q.pop_front();
        if (bus.alu_result) begin
            k = find(bus.alu_rob_pos);
            if (k >= 0) begin
                q[k].ready = 1; q[k].val = bus.alu_val;
                q[k].jump = bus.alu_jump; q[k].npc = bus.alu_next_pc;
            end
        end
        if (bus.lsb_result) begin
            k = find(bus.lsb_rob_pos);
            if (k >= 0) begin q[k].ready = 1; q[k].val = bus.lsb_val; end
        end
        if (retire) begin
            if (e.typ == 2'b01 && e.jump != e.pred) begin
                q.delete();
                mtail = 0;
                e_rollback = 1;
                e_rbpc = e.npc;
                return;
            end
            if (e.typ == 2'b00) begin
                e_commit = 1; e_rd = e.rd; e_val = e.val; e_pos = e.pos;
            end else if (e.typ == 2'b10) begin
                e_store = 1; e_pos = e.pos;
            end
        end
        if (bus.issue && !was_full) begin
            n.pos = 4'(mtail); n.typ = bus.issue_type; n.rd = bus.issue_rd;
            n.val = bus.issue_val; n.ready = bus.issue_ready;
            n.pred = bus.issue_pred_jump; n.jump = bus.issue_pred_jump; n.npc = '0;
            q.push_back(n);
            mtail = (mtail + 1) % 16;
        end
    endtask

    task automatic idle();
        rst = 0; rdy = 1;
        bus.issue = 0; bus.issue_type = 2'b00; bus.issue_rd = 5'($urandom);
        bus.issue_ready = 0; bus.issue_val = $urandom; bus.issue_pred_jump = 0;
        bus.alu_result = 0; bus.alu_rob_pos = 4'($urandom); bus.alu_val = $urandom;
        bus.alu_jump = 0; bus.alu_next_pc = $urandom;
        bus.lsb_result = 0; bus.lsb_rob_pos = 4'($urandom); bus.lsb_val = $urandom;
        bus.q1_pos = 4'($urandom); bus.q2_pos = 4'($urandom);
    endtask

    task automatic cycle();
        #1;
        check_outputs();
        model_step();
        @(posedge clk);
        @(negedge clk);
        idle();
    endtask

    task automatic do_issue(logic [1:0] t, logic [4:0] rd, bit rdy_now, logic [31:0] v, bit pj);
        bus.issue = 1; bus.issue_type = t; bus.issue_rd = rd;
        bus.issue_ready = rdy_now; bus.issue_val = v; bus.issue_pred_jump = pj;
    endtask

    task automatic do_alu(logic [3:0] p, logic [31:0] v, bit j, logic [31:0] npc);
        bus.alu_result = 1; bus.alu_rob_pos = p; bus.alu_val = v;
        bus.alu_jump = j; bus.alu_next_pc = npc;
    endtask

    initial begin
        int pend[$];
        int r, k;
        bit alu_used;

        idle();
        rst = 1;
        #1 model_step();
        @(posedge clk);
        @(negedge clk);
        idle();

        // Reg-write completed by ALU then retired
        do_issue(2'b00, 5'd5, 0, 32'h0, 0); cycle();
        do_alu(4'd0, 32'h1234, 0, 32'h0);   cycle();
        cycle();
        #1;
        check("d_commit", 32'(bus.commit), 32'd1);
        check("d_commit_rd", 32'(bus.commit_rd), 32'd5);
        check("d_commit_val", bus.commit_val, 32'h1234);
        check("d_commit_pos", 32'(bus.commit_rob_pos), 32'd0);
        cycle();
        #1 check("d_commit_pulse", 32'(bus.commit), 32'd0);

        // Fill to 16, 17th rejected
        rst = 1; cycle();
        for (int i = 0; i < 16; i++) begin
            do_issue(2'b00, 5'(i + 1), 0, 32'(i), 0); cycle();
        end
        #1;
        check("d_full", 32'(bus.rob_full), 32'd1);
        check("d_full_tail", 32'(bus.next_rob_pos), 32'd0);
        do_issue(2'b00, 5'd31, 0, 32'hDEAD, 0); cycle();
        #1 check("d_full_tail2", 32'(bus.next_rob_pos), 32'd0);

        // Same-cycle ALU forwarding
        bus.q1_pos = 4'd3; do_alu(4'd3, 32'hAB, 0, 32'h0);
        #1;
        check("d_fwd_ready", 32'(bus.q1_ready), 32'd1);
        check("d_fwd_val", bus.q1_val, 32'hAB);
        cycle();

        // Full ROB with ready head: issue rejected on the retire edge, then accepted at wrapped tail
        do_alu(4'd0, 32'h55, 0, 32'h0); cycle();
        do_issue(2'b00, 5'd9, 0, 32'h9, 0); cycle();
        #1;
        check("d_wrap_full", 32'(bus.rob_full), 32'd0);
        check("d_wrap_tail", 32'(bus.next_rob_pos), 32'd0);
        check("d_wrap_commit_val", bus.commit_val, 32'h55);
        do_issue(2'b00, 5'd9, 0, 32'h9, 0); cycle();
        #1;
        check("d_wrap_tail2", 32'(bus.next_rob_pos), 32'd1);
        check("d_wrap_full2", 32'(bus.rob_full), 32'd1);

        // Reset mid-stream with commit high; also overrides rdy=0
        rst = 1; cycle();
        for (int i = 0; i < 6; i++) begin
            do_issue(2'b00, 5'(i + 10), 0, 32'(i), 0); cycle();
        end
        do_alu(4'd0, 32'h77, 0, 32'h0); cycle();
        cycle();
        #1 check("d_pre_rst_commit", 32'(bus.commit), 32'd1);
        rst = 1; rdy = 0; do_issue(2'b00, 5'd1, 1, 32'h1, 0); do_alu(4'd1, 32'h2, 0, 32'h0);
        cycle();
        #1;
        check("d_rst_commit", 32'(bus.commit), 32'd0);
        check("d_rst_val", bus.commit_val, 32'd0);
        check("d_rst_full", 32'(bus.rob_full), 32'd0);
        check("d_rst_tail", 32'(bus.next_rob_pos), 32'd0);

        // Mispredicted branch, rollback held through rdy=0, issue ignored during flush
        do_issue(2'b01, 5'd0, 0, 32'h0, 0); cycle();
        do_issue(2'b00, 5'd3, 0, 32'h3, 0); do_alu(4'd0, 32'h0, 1, 32'h100); cycle();
        cycle();
        #1;
        check("d_rb", 32'(bus.rollback), 32'd1);
        check("d_rb_pc", bus.rollback_pc, 32'h100);
        check("d_rb_tail", 32'(bus.next_rob_pos), 32'd0);
        check("d_rb_full", 32'(bus.rob_full), 32'd0);
        rdy = 0; cycle();
        #1 check("d_rb_held", 32'(bus.rollback), 32'd1);
        do_issue(2'b00, 5'd4, 1, 32'h4, 0); cycle();
        #1;
        check("d_rb_clear", 32'(bus.rollback), 32'd0);
        check("d_rb_issue_ign", 32'(bus.next_rob_pos), 32'd0);

        // Randomized traffic
        for (int cyc = 0; cyc < 600; cyc++) begin
            r = $urandom_range(0, 199);
            if (r < 2)       rst = 1;
            else if (r < 20) rdy = 0;
            if ($urandom_range(0, 99) < 55) begin
                do_issue(2'($urandom_range(0, 2)), 5'($urandom), 0, $urandom, 1'($urandom));
                bus.issue_ready = (bus.issue_type != 2'b01) && ($urandom_range(0, 3) == 0);
            end
            pend.delete();
            foreach (q[i]) if (!q[i].ready) pend.push_back(i);
            alu_used = 0;
            if (pend.size() > 0 && $urandom_range(0, 99) < 60) begin
                k = pend[$urandom_range(0, pend.size() - 1)];
                do_alu(q[k].pos, $urandom, 1'($urandom), $urandom);
                alu_used = 1;
            end else if ($urandom_range(0, 9) == 0) begin
                do_alu(4'($urandom), $urandom, 1'($urandom), $urandom);
                alu_used = 1;
            end
            if (pend.size() > 0 && $urandom_range(0, 99) < 40) begin
                k = pend[$urandom_range(0, pend.size() - 1)];
                if (q[k].typ != 2'b01 && !(alu_used && q[k].pos == bus.alu_rob_pos)) begin
                    bus.lsb_result = 1; bus.lsb_rob_pos = q[k].pos; bus.lsb_val = $urandom;
                end
            end
            if ($urandom_range(0, 3) == 0 && q.size() > 0)
                bus.q1_pos = q[$urandom_range(0, q.size() - 1)].pos;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
